// File: rtl/bird_ctrl_if.sv
// Signal bundle between bird_ctrl and its environment: buttons, frame/collision
// events in, game state and motion commands out.
interface bird_ctrl_if;
  logic        frame_tick;
  logic        btn_flap;
  logic        btn_dive;
  logic        out_of_bound;
  logic        collide;
  logic        pass_pulse;
  logic [1:0]  state;
  logic        up;
  logic        down;
  logic [15:0] score;

  modport master (
    output frame_tick, btn_flap, btn_dive, out_of_bound, collide, pass_pulse,
    input  state, up, down, score
  );

  modport slave (
    input  frame_tick, btn_flap, btn_dive, out_of_bound, collide, pass_pulse,
    output state, up, down, score
  );
endinterface

// File: rtl/bird_ctrl.sv
// Game sequencer: READY/RUNNING/OVER FSM, button conditioning into
// frame-aligned up/down commands, and the saturating per-run score.
module bird_ctrl #(
  parameter int FLAP_FRAMES      = 8,
  parameter int FLAP_COOLDOWN    = 4,
  parameter int OVER_HOLD_FRAMES = 60
) (
  input  logic        clk,
  input  logic        rstn,
  bird_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    GAME_READY   = 2'd0,
    GAME_RUNNING = 2'd1,
    GAME_OVER    = 2'd2
  } state_t;

  localparam logic [7:0] LP_FLAP = 8'(FLAP_FRAMES);
  localparam logic [7:0] LP_COOL = 8'(FLAP_COOLDOWN);
  localparam logic [7:0] LP_HOLD = 8'(OVER_HOLD_FRAMES);

  state_t      r_state;
  logic        r_flap_s1, r_flap_s2, r_flap_d, r_press_flap;
  logic        r_dive_s1, r_dive_s2;
  logic [7:0]  r_flap_cnt, r_cool_cnt, r_hold_cnt;
  logic        r_flap_pend;
  logic        r_up, r_down;
  logic [15:0] r_score;

  logic [7:0]  w_flap_cnt_nx, w_cool_cnt_nx;
  logic        w_pend_nx, w_up_nx, w_down_nx;
  logic        w_hit;

  assign w_hit = bus.out_of_bound | bus.collide;

  // Press pulse is registered so the edge detector adds a full clk of latency.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_flap_s1    <= 1'b0;
      r_flap_s2    <= 1'b0;
      r_flap_d     <= 1'b0;
      r_press_flap <= 1'b0;
      r_dive_s1    <= 1'b0;
      r_dive_s2    <= 1'b0;
    end else begin
      r_flap_s1    <= bus.btn_flap;
      r_flap_s2    <= r_flap_s1;
      r_flap_d     <= r_flap_s2;
      r_press_flap <= r_flap_s2 & ~r_flap_d;
      r_dive_s1    <= bus.btn_dive;
      r_dive_s2    <= r_dive_s1;
    end
  end

  // Tick evaluation uses the old pending flag; a press in the same cycle lands after it.
  always_comb begin
    w_flap_cnt_nx = r_flap_cnt;
    w_cool_cnt_nx = r_cool_cnt;
    w_pend_nx     = r_flap_pend;
    w_up_nx       = r_up;
    if (bus.frame_tick) begin
      if (r_flap_cnt != 8'd0) begin
        w_flap_cnt_nx = r_flap_cnt - 8'd1;
        w_up_nx       = (r_flap_cnt != 8'd1);
        if (r_flap_cnt == 8'd1) w_cool_cnt_nx = LP_COOL;
      end else if (r_cool_cnt != 8'd0) begin
        w_cool_cnt_nx = r_cool_cnt - 8'd1;
        w_up_nx       = 1'b0;
        w_pend_nx     = 1'b0;
      end else if (r_flap_pend) begin
        w_flap_cnt_nx = LP_FLAP;
        w_up_nx       = 1'b1;
        w_pend_nx     = 1'b0;
      end else begin
        w_up_nx       = 1'b0;
      end
    end
    if (r_press_flap) w_pend_nx = 1'b1;
    w_down_nx = bus.frame_tick ? (r_dive_s2 & ~w_up_nx) : r_down;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= GAME_READY;
      r_flap_cnt  <= 8'd0;
      r_cool_cnt  <= 8'd0;
      r_hold_cnt  <= 8'd0;
      r_flap_pend <= 1'b0;
      r_up        <= 1'b0;
      r_down      <= 1'b0;
    end else begin
      case (r_state)
        GAME_READY: begin
          if (r_press_flap) r_state <= GAME_RUNNING;
        end
        GAME_RUNNING: begin
          if (w_hit) begin
            r_state     <= GAME_OVER;
            r_flap_cnt  <= 8'd0;
            r_cool_cnt  <= 8'd0;
            r_hold_cnt  <= 8'd0;
            r_flap_pend <= 1'b0;
            r_up        <= 1'b0;
            r_down      <= 1'b0;
          end else begin
            r_flap_cnt  <= w_flap_cnt_nx;
            r_cool_cnt  <= w_cool_cnt_nx;
            r_flap_pend <= w_pend_nx;
            r_up        <= w_up_nx;
            r_down      <= w_down_nx;
          end
        end
        GAME_OVER: begin
          if (bus.frame_tick && (r_hold_cnt != LP_HOLD)) r_hold_cnt <= r_hold_cnt + 8'd1;
          if (r_press_flap && (r_hold_cnt == LP_HOLD)) r_state <= GAME_READY;
        end
        default: r_state <= GAME_READY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_score <= 16'd0;
    end else if ((r_state == GAME_READY) && r_press_flap) begin
      r_score <= 16'd0;
    end else if ((r_state == GAME_RUNNING) && bus.pass_pulse && (r_score != 16'hFFFF)) begin
      r_score <= r_score + 16'd1;
    end
  end

  assign bus.state = r_state;
  assign bus.up    = r_up;
  assign bus.down  = r_down;
  assign bus.score = r_score;

endmodule

// File: tb/tb_bird_ctrl.sv
// Directed bench for bird_ctrl: a per-frame vector table for flap/cooldown/dive
// behaviour plus hand-written sequences for game over, score and reset.
module tb_bird_ctrl;

  logic clk;
  logic rstn;
  int   n_checks;
  int   n_errors;

  bird_ctrl_if bus();

  bird_ctrl #(
    .FLAP_FRAMES(8),
    .FLAP_COOLDOWN(4),
    .OVER_HOLD_FRAMES(60)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic press;
    logic dive;
    logic exp_up;
    logic exp_down;
  } vec_t;

  vec_t tbl[27];
  int   n_rows;

  task automatic add_row(input logic p, input logic d, input logic u, input logic dn);
    tbl[n_rows] = '{press: p, dive: d, exp_up: u, exp_down: dn};
    n_rows++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic press_flap();
    @(negedge clk) bus.btn_flap = 1'b1;
    repeat (2) @(negedge clk);
    bus.btn_flap = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      @(negedge clk) bus.frame_tick = 1'b1;
      @(negedge clk) bus.frame_tick = 1'b0;
    end
  endtask

  task automatic pass_pulses(input int n);
    repeat (n) begin
      @(negedge clk) bus.pass_pulse = 1'b1;
      @(negedge clk) bus.pass_pulse = 1'b0;
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    n_rows   = 0;
    rstn = 1'b0;
    bus.frame_tick = 1'b0;
    bus.btn_flap = 1'b0;
    bus.btn_dive = 1'b0;
    bus.out_of_bound = 1'b0;
    bus.collide = 1'b0;
    bus.pass_pulse = 1'b0;

    // press, dive, expected up, expected down after the tick
    add_row(1, 0, 1, 0);
    for (int i = 0; i < 7; i++) add_row(0, 0, 1, 0);
    add_row(0, 0, 0, 0);
    add_row(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) add_row(0, 0, 0, 0);
    add_row(1, 0, 1, 0);
    for (int i = 0; i < 7; i++) add_row(0, 1, 1, 0);
    add_row(0, 1, 0, 1);
    add_row(0, 0, 0, 0);
    add_row(0, 1, 0, 1);
    add_row(0, 0, 0, 0);
    add_row(0, 0, 0, 0);
    add_row(1, 1, 1, 0);

    repeat (3) @(negedge clk);
    check("reset_state", 32'(bus.state), 32'd0);
    check("reset_up",    32'(bus.up),    32'd0);
    check("reset_down",  32'(bus.down),  32'd0);
    check("reset_score", 32'(bus.score), 32'd0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Start press: state changes exactly four clk after the button edge
    bus.btn_flap = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("start_latency_clk%0d", k), 32'(bus.state), (k < 4) ? 32'd0 : 32'd1);
    end
    bus.btn_flap = 1'b0;
    repeat (4) @(negedge clk);
    ticks(1);
    check("start_up_consumed", 32'(bus.up),    32'd0);
    check("start_score",       32'(bus.score), 32'd0);

    for (int r = 0; r < n_rows; r++) begin
      bus.btn_dive = tbl[r].dive;
      if (tbl[r].press) press_flap();
      else repeat (4) @(negedge clk);
      ticks(1);
      check($sformatf("row%0d_up", r),    32'(bus.up),    32'(tbl[r].exp_up));
      check($sformatf("row%0d_down", r),  32'(bus.down),  32'(tbl[r].exp_down));
      check($sformatf("row%0d_state", r), 32'(bus.state), 32'd1);
    end
    bus.btn_dive = 1'b0;

    pass_pulses(3);
    check("score_three", 32'(bus.score), 32'd3);
    check("midflap_up",  32'(bus.up),    32'd1);

    // Collision coincident with a pass pulse: OVER wins, score still counts
    @(negedge clk) begin bus.collide = 1'b1; bus.pass_pulse = 1'b1; end
    @(negedge clk) begin bus.collide = 1'b0; bus.pass_pulse = 1'b0; end
    check("over_state", 32'(bus.state), 32'd2);
    check("over_up",    32'(bus.up),    32'd0);
    check("over_down",  32'(bus.down),  32'd0);
    check("over_score", 32'(bus.score), 32'd4);
    pass_pulses(1);
    check("over_pass_ignored", 32'(bus.score), 32'd4);

    ticks(30);
    press_flap();
    check("hold30_press_dropped", 32'(bus.state), 32'd2);
    ticks(29);
    press_flap();
    check("hold59_press_dropped", 32'(bus.state), 32'd2);
    ticks(1);
    press_flap();
    check("hold60_to_ready", 32'(bus.state), 32'd0);
    check("ready_score_held", 32'(bus.score), 32'd4);
    pass_pulses(1);
    check("ready_pass_ignored", 32'(bus.score), 32'd4);
    press_flap();
    check("restart_state", 32'(bus.state), 32'd1);
    check("restart_score", 32'(bus.score), 32'd0);

    pass_pulses(5);
    check("score_five", 32'(bus.score), 32'd5);
    press_flap();
    ticks(1);
    check("preflap_up", 32'(bus.up), 32'd1);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check("async_rst_state", 32'(bus.state), 32'd0);
    check("async_rst_up",    32'(bus.up),    32'd0);
    check("async_rst_score", 32'(bus.score), 32'd0);
    @(negedge clk) rstn = 1'b1;
    repeat (2) @(negedge clk);

    press_flap();
    check("rerun_state", 32'(bus.state), 32'd1);
    @(negedge clk);
    force dut.r_score = 16'hFFFE;
    #1 release dut.r_score;
    pass_pulses(1);
    check("score_to_max", 32'(bus.score), 32'hFFFF);
    pass_pulses(1);
    check("score_saturate", 32'(bus.score), 32'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
